fifo_reg_ctrl: RTL
==================

Name: fifo_reg_ctrl

Overview:
Controller that sequences the 5-bit register-file storage of the FIFO. It holds the write/read pointers and occupancy count, and drives one-hot write-select (WS) and read-select (RS) lines to the DEPTH register rows. It flags full/empty and reports overflow/underflow attempts. It sits between the FIFO top-level request interface and the array of 5-bit register rows; the data bus is not routed through this block.

Parameters:
DEPTH, 8, number of 5-bit register rows; power of two, 2..32
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock shared with register rows
clear  in  1  asynchronous, active-low reset
wr_req  in  1  write request; data on row DataIn bus this cycle
rd_req  in  1  read request; pops the word currently presented
flush  in  1  synchronous flush of pointers/count; storage contents untouched
ws  out  DEPTH  one-hot write select to register rows (WS)
rs  out  DEPTH  one-hot read select to register rows (RS)
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  PTR_W+1  occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write refused
underflow  out  1  one-cycle pulse: read refused

Behaviour:
- Reset (clear=0, async): wr_ptr=0, rd_ptr=0, count=0; empty=1, full=0, overflow=0, underflow=0; ws=0, rs=0.
- rd_acc = rd_req & !empty.
- wr_acc = wr_req & (!full | rd_acc). Write while full is allowed only with a simultaneous accepted read.
- ws = onehot(wr_ptr) when wr_acc, else 0. Combinational, so the row captures DataIn at the next clk edge.
- rs = onehot(rd_ptr) when !empty, else 0. Combinational show-ahead: the head word is on the row outputs whenever non-empty. rd_req consumes it at the edge.
- At the clock edge:
  - wr_acc: wr_ptr <= wr_ptr+1, mod DEPTH wrap from DEPTH-1 to 0.
  - rd_acc: rd_ptr <= rd_ptr+1, mod DEPTH.
  - count <= count + wr_acc - rd_acc.
- Latency:
  - Write at edge N: empty deasserts and rs selects the row in cycle N+1.
  - Read at edge N: the next word is presented in cycle N+1.
- full/empty/count are registered, decoded from count, with no combinational path from requests.
- Simultaneous wr_acc & rd_acc:
  - count unchanged, both pointers advance.
  - When full: the row being read is at rd_ptr and the write lands at wr_ptr == rd_ptr. The read data is sampled before the edge, so there is no hazard.
- wr_req & rd_req while empty: the read is refused (underflow pulse), the write is accepted, and count becomes 1.
- overflow <= wr_req & !wr_acc; underflow <= rd_req & !rd_acc. Each is registered and high for exactly one cycle per refused request.
- flush:
  - Next edge: pointers=0, count=0, empty=1, errors=0.
  - flush overrides wr_req/rd_req that cycle; ws is forced to 0 while flush=1.
- clear asserted mid-operation: all state returns to reset values immediately, and ws/rs go to 0 asynchronously.
- Invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except count==DEPTH when the pointers are equal and full.

Decomposition:
- Shared package fifo_pkg: DEPTH default, PTR_W derivation, count width constant (PTR_W+1).
- One sub-module: onehot_dec (PTR_W-bit index plus enable -> DEPTH one-hot). Instantiated twice, for ws and rs.
- Pointer/count logic stays in fifo_reg_ctrl.

Test Plan:
- Reset: clear=0 with random requests -> ws=0, rs=0, empty=1, full=0, count=0. Release clear, idle one cycle -> state unchanged.
- Fill: 8 consecutive writes (DEPTH=8) -> ws walks 0x01..0x80, count 1..8, full=1 after 8th edge. A 9th write -> overflow pulses for one cycle, ws=0, count stays 8.
- Drain/wrap: from full, 8 reads -> rs walks 0x01..0x80, empty=1 after last. A further read -> underflow pulse, rs=0. Then 3 writes/3 reads -> ws/rs wrap through rows 0..2, count returns to 0.
- Concurrent:
  - count=4, wr_req&rd_req for 10 cycles -> count holds 4, both pointers advance 10 mod 8.
  - At full, wr&rd together -> no overflow, full stays 1.
  - At empty, wr&rd together -> underflow, count becomes 1.
- Flush: count=5, flush=1 with wr_req=1 -> ws=0 that cycle, next cycle count=0, empty=1, pointers 0, rs=0.
- Async reset mid-stream: assert clear between edges during writes -> outputs go to reset values before the next edge, with no spurious ws pulse.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing for the register-file FIFO controller: default depth, pointer and count widths.
// Pure constants, no latency or backpressure of its own.
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

  // Count needs one extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_reg_ctrl_onehot_dec.sv
// Binary index to one-hot row select, all zeros when disabled.
// Purely combinational, zero latency, no backpressure.
module onehot_dec
  import fifo_pkg::*;
#(
  parameter  int N     = FIFO_DEPTH,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N-1:0]     onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_reg_ctrl.sv
// Pointer/count sequencer for the 5-bit register rows: one-hot WS/RS, full/empty, refused-request pulses.
// Show-ahead reads with one-cycle update latency; writes refused when full unless a read is accepted alongside.
module fifo_reg_ctrl
  import fifo_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic             flush,
  output logic [DEPTH-1:0] ws,
  output logic [DEPTH-1:0] rs,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd_acc;
  logic             wr_acc;

  // Flags come only from the count register, never from the request inputs.
  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);

  assign rd_acc = rd_req & ~empty;
  assign wr_acc = wr_req & (~full | rd_acc);

  // Selects are also gated by clear so a held request cannot pulse a row during reset.
  onehot_dec #(.N(DEPTH)) u_ws_dec (
    .idx    (wr_ptr),
    .en     (wr_acc & ~flush & clear),
    .onehot (ws)
  );

  onehot_dec #(.N(DEPTH)) u_rs_dec (
    .idx    (rd_ptr),
    .en     (~empty & clear),
    .onehot (rs)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow gives the mod-DEPTH wrap.
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow  <= wr_req & ~wr_acc;
      underflow <= rd_req & ~rd_acc;
    end
  end

endmodule
